// File: rtl/micro_pkg.sv
// Shared opcodes, FSM encoding and instruction-field helpers for the parametrised Harvard core.
package micro_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_MOV  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_OR   = 4'h6;
   localparam logic [3:0] OP_XOR  = 4'h7;
   localparam logic [3:0] OP_LD   = 4'h8;
   localparam logic [3:0] OP_ST   = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_JZ   = 4'hB;
   localparam logic [3:0] OP_JC   = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hD;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_MEM  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   // Widest instruction the field helpers accept; callers zero-extend and narrow with a cast.
   localparam int MAX_IW = 128;

   function automatic logic [MAX_IW-1:0] f_op(input logic [MAX_IW-1:0] ins,
                                              input int dw, input int ra);
      return (ins >> (dw + 2*ra)) & MAX_IW'(4'hF);
   endfunction

   function automatic logic [MAX_IW-1:0] f_rd(input logic [MAX_IW-1:0] ins,
                                              input int dw, input int ra);
      return (ins >> (dw + ra)) & ((MAX_IW'(1) << ra) - MAX_IW'(1));
   endfunction

   function automatic logic [MAX_IW-1:0] f_rs(input logic [MAX_IW-1:0] ins,
                                              input int dw, input int ra);
      return (ins >> dw) & ((MAX_IW'(1) << ra) - MAX_IW'(1));
   endfunction

   function automatic logic [MAX_IW-1:0] f_imm(input logic [MAX_IW-1:0] ins,
                                               input int dw);
      return ins & ((MAX_IW'(1) << dw) - MAX_IW'(1));
   endfunction

endpackage

// File: rtl/micro_regfile_param.sv
// General register file: two combinational read ports, one synchronous write port, async clear.
module micro_regfile_param #(
   parameter int DATA_W = 8,
   parameter int NREG   = 4,
   parameter int RA     = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [RA-1:0]     wa_i,
   input  logic [DATA_W-1:0] wd_i,
   input  logic [RA-1:0]     ra_rd_i,
   input  logic [RA-1:0]     ra_rs_i,
   output logic [DATA_W-1:0] rd_o,
   output logic [DATA_W-1:0] rs_o
);

   logic [DATA_W-1:0] regs_q [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   assign rd_o = regs_q[ra_rd_i];
   assign rs_o = regs_q[ra_rs_i];

endmodule

// File: rtl/micro_harvard_param.sv
// Parametrised Harvard micro core: single-cycle RUN, stalling data-bus access in MEM, sticky HALT.
module micro_harvard_param
   import micro_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NREG   = 4,
   parameter int PC_W   = 8,
   parameter int IW     = 4 + 2*$clog2(NREG) + DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IW-1:0]     i_instruccion,
   input  logic [DATA_W-1:0] i_dato,
   input  logic              i_ack,
   output logic [PC_W-1:0]   o_direccion_instruccion,
   output logic [DATA_W-1:0] o_salida_datos,
   output logic [DATA_W-1:0] o_direccion_datos,
   output logic              o_req,
   output logic              RW,
   output logic              o_halt
);

   localparam int RA = $clog2(NREG);

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              z_q, z_d;
   logic              c_q, c_d;
   logic              rw_q, rw_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [RA-1:0]     ldrd_q, ldrd_d;

   logic [MAX_IW-1:0] ins_w;
   logic [3:0]        op;
   logic [RA-1:0]     rd_a, rs_a;
   logic [DATA_W-1:0] imm;
   logic [PC_W-1:0]   imm_pc, pc_inc;
   logic [DATA_W-1:0] rd_val, rs_val;

   logic              rf_we;
   logic [RA-1:0]     rf_wa;
   logic [DATA_W-1:0] rf_wd;

   logic [DATA_W:0]   sum_w, dif_w;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c;

   assign ins_w  = MAX_IW'(i_instruccion);
   assign op     = 4'(f_op(ins_w, DATA_W, RA));
   assign rd_a   = RA'(f_rd(ins_w, DATA_W, RA));
   assign rs_a   = RA'(f_rs(ins_w, DATA_W, RA));
   assign imm    = DATA_W'(f_imm(ins_w, DATA_W));
   assign imm_pc = imm[PC_W-1:0];
   assign pc_inc = pc_q + PC_W'(1);

   micro_regfile_param #(
      .DATA_W (DATA_W),
      .NREG   (NREG),
      .RA     (RA)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we_i    (rf_we),
      .wa_i    (rf_wa),
      .wd_i    (rf_wd),
      .ra_rd_i (rd_a),
      .ra_rs_i (rs_a),
      .rd_o    (rd_val),
      .rs_o    (rs_val)
   );

   // Zero-extended operands put carry-out / borrow in the extra top bit.
   assign sum_w = {1'b0, rd_val} + {1'b0, rs_val};
   assign dif_w = {1'b0, rd_val} - {1'b0, rs_val};

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      case (op)
         OP_ADD:  {alu_c, alu_res} = sum_w;
         OP_SUB:  {alu_c, alu_res} = dif_w;
         OP_AND:  alu_res = rd_val & rs_val;
         OP_OR:   alu_res = rd_val | rs_val;
         OP_XOR:  alu_res = rd_val ^ rs_val;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      z_d     = z_q;
      c_d     = c_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ldrd_d  = ldrd_q;
      rf_we   = 1'b0;
      rf_wa   = rd_a;
      rf_wd   = alu_res;
      case (state_q)
         ST_RUN: begin
            pc_d = pc_inc;
            case (op)
               OP_LDI: begin
                  rf_we = 1'b1;
                  rf_wd = imm;
               end
               OP_MOV: begin
                  rf_we = 1'b1;
                  rf_wd = rs_val;
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                  rf_we = 1'b1;
                  z_d   = (alu_res == '0);
                  c_d   = alu_c;
               end
               OP_LD, OP_ST: begin
                  state_d = ST_MEM;
                  pc_d    = pc_q;
                  addr_d  = imm;
                  rw_d    = (op == OP_ST);
                  ldrd_d  = rd_a;
                  if (op == OP_ST) begin
                     wdata_d = rs_val;
                  end
               end
               OP_JMP: pc_d = imm_pc;
               OP_JZ:  if (z_q) pc_d = imm_pc;
               OP_JC:  if (c_q) pc_d = imm_pc;
               OP_HALT: begin
                  state_d = ST_HALT;
                  pc_d    = pc_q;
               end
               default: ;
            endcase
         end
         // Bus outputs are registers, so they hold on their own until the ack edge.
         ST_MEM: begin
            if (i_ack) begin
               state_d = ST_RUN;
               pc_d    = pc_inc;
               if (!rw_q) begin
                  rf_we = 1'b1;
                  rf_wa = ldrd_q;
                  rf_wd = i_dato;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         pc_q    <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ldrd_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         z_q     <= z_d;
         c_q     <= c_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ldrd_q  <= ldrd_d;
      end
   end

   assign o_direccion_instruccion = pc_q;
   assign o_salida_datos          = wdata_q;
   assign o_direccion_datos       = addr_q;
   assign o_req                   = (state_q == ST_MEM);
   assign RW                      = rw_q;
   assign o_halt                  = (state_q == ST_HALT);

endmodule

// File: tb/tb_micro_harvard_param.sv
// Scoreboard bench: an ISA-level model predicts the executed-PC trace and bus transactions.
module tb_micro_harvard_param;

   localparam int DW = 8, NR = 4, PW = 8, RA = 2, IW = 4 + 2*RA + DW;
   localparam int DW16 = 16, NR16 = 8, RA16 = 3, IW16 = 4 + 2*RA16 + DW16;

   typedef struct packed {
      logic          rw;
      logic [DW-1:0] addr;
      logic [DW-1:0] data;
   } bus_t;

   logic clk = 1'b0;
   logic rst, ack, mon_en, mem_load;
   int   ack_pct;
   int   errors = 0;
   int   checks = 0;

   logic [IW-1:0] rom [256];
   logic [DW-1:0] dmem [256];
   logic [DW-1:0] dmem_seed [256];
   logic [IW-1:0] instr;
   logic [DW-1:0] dato, wdata, daddr;
   logic [PW-1:0] pc;
   logic          req, rw, halt;

   bus_t          exp_bus [$];
   logic [PW-1:0] exp_pc [$];
   logic [PW-1:0] exp_halt_pc;
   bus_t          b, cur;
   logic [PW-1:0] mem_pc;
   logic          prev_req, prev_ack;

   logic            rst16, ack16;
   logic [IW16-1:0] rom16 [256];
   logic [IW16-1:0] instr16;
   logic [DW16-1:0] dato16, wdata16, daddr16;
   logic [7:0]      pc16;
   logic            req16, rw16, halt16;

   always #5 clk = ~clk;

   assign instr   = rom[pc];
   assign dato    = dmem[daddr];
   assign instr16 = rom16[pc16];
   assign dato16  = 16'h0;

   micro_harvard_param #(.DATA_W(DW), .NREG(NR), .PC_W(PW)) dut (
      .clk(clk), .rst(rst), .i_instruccion(instr), .i_dato(dato), .i_ack(ack),
      .o_direccion_instruccion(pc), .o_salida_datos(wdata), .o_direccion_datos(daddr),
      .o_req(req), .RW(rw), .o_halt(halt)
   );

   micro_harvard_param #(.DATA_W(DW16), .NREG(NR16), .PC_W(8)) dut16 (
      .clk(clk), .rst(rst16), .i_instruccion(instr16), .i_dato(dato16), .i_ack(ack16),
      .o_direccion_instruccion(pc16), .o_salida_datos(wdata16), .o_direccion_datos(daddr16),
      .o_req(req16), .RW(rw16), .o_halt(halt16)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic logic [IW-1:0] mk(input int op, input int rd, input int rs, input int imm);
      return {4'(op), RA'(rd), RA'(rs), DW'(imm)};
   endfunction

   function automatic logic [IW16-1:0] mk16(input int op, input int rd, input int rs, input int imm);
      return {4'(op), RA16'(rd), RA16'(rs), DW16'(imm)};
   endfunction

   // Data memory seen by the core: reloaded from the seed while mem_load is high.
   always @(posedge clk) begin
      if (mem_load) begin
         for (int a = 0; a < 256; a++) dmem[a] <= dmem_seed[a];
      end else if (!rst && req && rw && ack) begin
         dmem[daddr] <= wdata;
      end
   end

   // Instruction-set reference: instantaneous memory, plain integer arithmetic.
   task automatic model_run();
      logic [DW-1:0] r [NR];
      logic [DW-1:0] m [256];
      logic          z, c;
      logic [IW-1:0] w;
      int            op, rd, rs, imm, p, nxt, s, steps;
      bus_t          t;
      for (int i = 0; i < NR; i++) r[i] = '0;
      for (int a = 0; a < 256; a++) m[a] = dmem_seed[a];
      z = 1'b0; c = 1'b0; p = 0;
      exp_pc.delete(); exp_bus.delete();
      exp_halt_pc = '0;
      for (steps = 0; steps < 4000; steps++) begin
         w   = rom[p];
         op  = int'(w[IW-1 -: 4]);
         rd  = int'(w[DW+RA +: RA]);
         rs  = int'(w[DW +: RA]);
         imm = int'(w[DW-1:0]);
         exp_pc.push_back(PW'(p));
         nxt = (p + 1) % 256;
         case (op)
            1: r[rd] = DW'(imm);
            2: r[rd] = r[rs];
            3: begin s = int'(r[rd]) + int'(r[rs]); c = (s > 255); r[rd] = DW'(s % 256); z = (r[rd] == 0); end
            4: begin c = (r[rd] < r[rs]); s = int'(r[rd]) - int'(r[rs]) + 256; r[rd] = DW'(s % 256); z = (r[rd] == 0); end
            5: begin r[rd] = r[rd] & r[rs]; c = 1'b0; z = (r[rd] == 0); end
            6: begin r[rd] = r[rd] | r[rs]; c = 1'b0; z = (r[rd] == 0); end
            7: begin r[rd] = r[rd] ^ r[rs]; c = 1'b0; z = (r[rd] == 0); end
            8: begin t.rw = 1'b0; t.addr = DW'(imm); t.data = '0; exp_bus.push_back(t); r[rd] = m[imm]; end
            9: begin t.rw = 1'b1; t.addr = DW'(imm); t.data = r[rs]; exp_bus.push_back(t); m[imm] = r[rs]; end
            10: nxt = imm;
            11: if (z) nxt = imm;
            12: if (c) nxt = imm;
            13: begin exp_halt_pc = PW'(p); break; end
            default: ;
         endcase
         p = nxt;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (prev_req) chk("req_release", 32'(req), 32'(!prev_ack));
         if (req && !prev_req) begin
            chk("txn_pending", 32'(exp_bus.size() > 0), 32'(1));
            if (exp_bus.size() > 0) begin
               b = exp_bus.pop_front();
               chk("txn_rw", 32'(rw), 32'(b.rw));
               chk("txn_addr", 32'(daddr), 32'(b.addr));
               if (b.rw) chk("txn_data", 32'(wdata), 32'(b.data));
            end
            cur    <= {rw, daddr, wdata};
            mem_pc <= pc;
         end else if (req) begin
            chk("bus_stable", 32'({rw, daddr, wdata}), 32'(cur));
            chk("pc_hold", 32'(pc), 32'(mem_pc));
         end
         if (!req && !halt) begin
            chk("instr_pending", 32'(exp_pc.size() > 0), 32'(1));
            if (exp_pc.size() > 0) chk("pc_seq", 32'(pc), 32'(exp_pc.pop_front()));
         end
         prev_req <= req;
         prev_ack <= ack;
      end else begin
         prev_req <= 1'b0;
         prev_ack <= 1'b0;
      end
   end

   task automatic run_prog(input int budget);
      int k;
      mon_en = 1'b0;
      @(negedge clk);
      rst = 1'b1; mem_load = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_pc", 32'(pc), 32'(0));
      chk("rst_req", 32'(req), 32'(0));
      chk("rst_rw", 32'(rw), 32'(0));
      chk("rst_halt", 32'(halt), 32'(0));
      chk("rst_wdata", 32'(wdata), 32'(0));
      chk("rst_daddr", 32'(daddr), 32'(0));
      model_run();
      @(posedge clk); #2;
      rst = 1'b0; mem_load = 1'b0; mon_en = 1'b1;
      for (k = 0; k < budget && !halt; k++) @(negedge clk);
      chk("halt_reached", 32'(halt), 32'(1));
      @(negedge clk); #1;
      chk("instr_left", 32'(exp_pc.size()), 32'(0));
      chk("txn_left", 32'(exp_bus.size()), 32'(0));
      repeat (10) begin
         @(negedge clk); #1;
         chk("halt_pc", 32'(pc), 32'(exp_halt_pc));
         chk("halt_flag", 32'(halt), 32'(1));
         chk("halt_req", 32'(req), 32'(0));
      end
      mon_en = 1'b0;
   endtask

   task automatic gen_random(input int len);
      int op, imm;
      for (int a = 0; a < 256; a++) rom[a] = mk(13, 0, 0, 0);
      for (int a = 0; a < len - 1; a++) begin
         op  = $urandom_range(0, 15);
         imm = $urandom_range(0, 255);
         if (op == 13) op = 3;
         if (op >= 10 && op <= 12) imm = $urandom_range(a + 1, len - 1);
         if (op == 8 || op == 9) imm = $urandom_range(0, 15);
         rom[a] = mk(op, $urandom_range(0, 3), $urandom_range(0, 3), imm);
      end
   endtask

   initial begin
      int k;
      rst = 1'b1; rst16 = 1'b1; ack = 1'b0; ack16 = 1'b0;
      ack_pct = 0; mon_en = 1'b0; mem_load = 1'b1;
      for (int a = 0; a < 256; a++) begin
         dmem_seed[a] = '0;
         rom[a]       = mk(13, 0, 0, 0);
         rom16[a]     = mk16(13, 0, 0, 0);
      end
      fork
         forever begin
            @(posedge clk); #1;
            ack = ($urandom_range(1, 100) <= ack_pct);
         end
      join_none

      // ADD without and with carry, JZ/JC taken and not taken, rd == rs doubling.
      rom[0]  = mk(1, 0, 0, 8'h05);  rom[1]  = mk(1, 1, 0, 8'h03);
      rom[2]  = mk(3, 0, 1, 0);      rom[3]  = mk(9, 0, 0, 8'h10);
      rom[4]  = mk(11, 0, 0, 8'h30); rom[5]  = mk(12, 0, 0, 8'h30);
      rom[6]  = mk(1, 0, 0, 8'hFF);  rom[7]  = mk(1, 1, 0, 8'h01);
      rom[8]  = mk(3, 0, 1, 0);      rom[9]  = mk(11, 0, 0, 8'h0B);
      rom[10] = mk(13, 0, 0, 0);     rom[11] = mk(12, 0, 0, 8'h0D);
      rom[12] = mk(13, 0, 0, 0);     rom[13] = mk(9, 0, 0, 8'h20);
      rom[14] = mk(3, 1, 1, 0);      rom[15] = mk(9, 0, 1, 8'h21);
      ack_pct = 60;
      run_prog(600);

      // PC wrap 0xFF -> 0, SUB borrow, LD followed by ST of the loaded register.
      for (int a = 0; a < 256; a++) rom[a] = mk(13, 0, 0, 0);
      rom[0]    = mk(12, 0, 0, 8'h05); rom[1] = mk(1, 1, 0, 8'h01);
      rom[2]    = mk(4, 0, 1, 0);      rom[3] = mk(10, 0, 0, 8'hFF);
      rom[8'hFF] = mk(0, 0, 0, 0);
      rom[5]    = mk(9, 0, 0, 8'h12);  rom[6] = mk(8, 2, 0, 8'h40);
      rom[7]    = mk(9, 0, 2, 8'h13);
      dmem_seed[8'h40] = 8'hA5;
      ack_pct = 35;
      run_prog(600);

      for (int n = 0; n < 8; n++) begin
         for (int a = 0; a < 16; a++) dmem_seed[a] = DW'($urandom_range(0, 255));
         gen_random(40);
         ack_pct = $urandom_range(25, 100);
         run_prog(1500);
      end

      // Reset in the middle of a stalled store abandons it and clears the registers.
      for (int a = 0; a < 256; a++) rom[a] = mk(13, 0, 0, 0);
      rom[0] = mk(1, 1, 0, 8'h77); rom[1] = mk(9, 0, 1, 8'h30);
      dmem_seed[8'h30] = '0;
      ack_pct = 0;
      @(negedge clk); rst = 1'b1; mem_load = 1'b1;
      repeat (2) @(negedge clk);
      @(posedge clk); #2; rst = 1'b0; mem_load = 1'b0;
      for (k = 0; k < 10 && !req; k++) @(negedge clk);
      chk("mm_req_up", 32'(req), 32'(1));
      chk("mm_addr", 32'(daddr), 32'(8'h30));
      chk("mm_rw", 32'(rw), 32'(1));
      chk("mm_data", 32'(wdata), 32'(8'h77));
      repeat (2) @(negedge clk);
      chk("mm_req_stall", 32'(req), 32'(1));
      #1 rst = 1'b1;
      #1;
      chk("mm_req_async", 32'(req), 32'(0));
      chk("mm_pc_async", 32'(pc), 32'(0));
      rom[0] = mk(9, 0, 1, 8'h31); rom[1] = mk(13, 0, 0, 0);
      ack_pct = 100;
      repeat (2) @(negedge clk);
      ack_pct = 0;
      @(posedge clk); #2; rst = 1'b0;
      @(negedge clk);
      chk("mm_no_write", 32'(dmem[8'h30]), 32'(0));
      chk("mm_restart_pc", 32'(pc), 32'(0));
      for (k = 0; k < 10 && !req; k++) @(negedge clk);
      chk("mm_st2_req", 32'(req), 32'(1));
      chk("mm_st2_addr", 32'(daddr), 32'(8'h31));
      chk("mm_regs_cleared", 32'(wdata), 32'(0));
      ack_pct = 100;
      for (k = 0; k < 10 && !halt; k++) @(negedge clk);
      chk("mm_halt_pc", 32'(pc), 32'(1));
      ack_pct = 0;

      // 16-bit, 8-register instance: 0xFFFF + 1 wraps to 0 with carry.
      rom16[0] = mk16(1, 5, 0, 16'hFFFF); rom16[1] = mk16(1, 6, 0, 16'h0001);
      rom16[2] = mk16(3, 5, 6, 0);        rom16[3] = mk16(12, 0, 0, 5);
      rom16[5] = mk16(9, 0, 5, 16'h1234);
      @(posedge clk); #2; rst16 = 1'b0;
      for (k = 0; k < 20 && !req16; k++) @(negedge clk);
      chk("w16_req", 32'(req16), 32'(1));
      chk("w16_pc_jc", 32'(pc16), 32'(5));
      chk("w16_addr", 32'(daddr16), 32'(16'h1234));
      chk("w16_sum", 32'(wdata16), 32'(0));
      chk("w16_rw", 32'(rw16), 32'(1));
      @(posedge clk); #1 ack16 = 1'b1;
      @(posedge clk); #1 ack16 = 1'b0;
      for (k = 0; k < 20 && !halt16; k++) @(negedge clk);
      chk("w16_halt", 32'(halt16), 32'(1));
      chk("w16_halt_pc", 32'(pc16), 32'(6));
      chk("w16_req_off", 32'(req16), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
